// File: rtl/fll_rate_monitor.sv
// FLL rate monitor: counts synchronized master bit-clock rising edges over a
// programmable window of local clocks and compares the count against a target
// with a deadband. Sticky speedup/slowdown interrupts are raised after
// CONSEC_N consecutive out-of-band windows in the same direction.
//
// state | meaning
// IDLE  | monitor off; partial window and run counters discarded
// ARM   | synchronizer settling for SYNC_STAGES+1 cycles, no edges counted
// COUNT | back-to-back windows of W = max(window_len_i, 2) cycles
module fll_rate_monitor #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int CONSEC_N    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK_IP_i,
    input  logic             RST_IP_i,
    input  logic             enable_i,
    input  logic             bitclk_master_i,
    input  logic [WIN_W-1:0] window_len_i,
    input  logic [CNT_W-1:0] target_cnt_i,
    input  logic [CNT_W-1:0] deadband_i,
    input  logic [1:0]       int_clr_i,
    output logic             Interrupt_speedup_o,
    output logic             Interrupt_slowdown_o,
    output logic [CNT_W-1:0] edge_cnt_o,
    output logic             cnt_valid_o,
    output logic             sat_o
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 1) + 1;
    localparam int RUN_W = 4;
    // ARM counts down from SYNC_STAGES to 0, giving SYNC_STAGES+1 cycles
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(SYNC_STAGES);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(CONSEC_N);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

    state_t state_q, state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise;
    logic [ARM_W-1:0]       arm_cnt_q;
    logic [WIN_W-1:0]       win_cnt_q;
    logic [WIN_W-1:0]       win_load;
    logic [CNT_W-1:0]       cnt_q, cnt_inc;
    logic                   sat_q, sat_inc;
    logic                   arm_load, count_start, count_en, win_last;
    logic [CNT_W:0]         cnt_ext, tgt_ext, db_ext;
    logic                   fast, slow, fast_set, slow_set;
    logic [RUN_W-1:0]       fast_run_q, slow_run_q, fast_run_nxt, slow_run_nxt;

    // State register
    always_ff @(posedge CLK_IP_i) begin
        if (RST_IP_i) state_q <= IDLE;
        else          state_q <= state_nxt;
    end

    // Next-state logic; dropping enable returns to IDLE from any state
    always_comb begin
        state_nxt = state_q;
        if (!enable_i) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_nxt = ARM;
                ARM:     if (arm_cnt_q == '0) state_nxt = COUNT;
                COUNT:   state_nxt = COUNT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM-derived control strobes
    always_comb begin
        arm_load    = (state_q == IDLE) && enable_i;
        count_start = (state_q == ARM) && enable_i && (arm_cnt_q == '0);
        count_en    = (state_q == COUNT) && enable_i;
        win_last    = count_en && (win_cnt_q == '0);
    end

    // Master clock synchronizer plus history flop for edge detection
    always_ff @(posedge CLK_IP_i) begin
        if (RST_IP_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bitclk_master_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge detect, clamped window reload value and saturating increment
    always_comb begin
        rise     = sync_q[SYNC_STAGES-1] & ~hist_q;
        win_load = (window_len_i < WIN_W'(2)) ? WIN_W'(1) : window_len_i - WIN_W'(1);
        cnt_inc  = cnt_q;
        sat_inc  = sat_q;
        if (rise) begin
            if (cnt_q == CNT_MAX) sat_inc = 1'b1;
            else                  cnt_inc = cnt_q + CNT_W'(1);
        end
    end

    // ARM settle timer and window down-counter
    always_ff @(posedge CLK_IP_i) begin
        if (RST_IP_i) begin
            arm_cnt_q <= '0;
            win_cnt_q <= '0;
        end else begin
            if (arm_load)
                arm_cnt_q <= ARM_LOAD;
            else if (state_q == ARM && arm_cnt_q != '0)
                arm_cnt_q <= arm_cnt_q - ARM_W'(1);
            if (count_start || win_last)
                win_cnt_q <= win_load;
            else if (count_en)
                win_cnt_q <= win_cnt_q - WIN_W'(1);
        end
    end

    // Edge accumulation and publication of each completed window
    always_ff @(posedge CLK_IP_i) begin
        if (RST_IP_i) begin
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            edge_cnt_o  <= '0;
            sat_o       <= 1'b0;
            cnt_valid_o <= 1'b0;
        end else begin
            cnt_valid_o <= win_last;
            if (win_last) begin
                edge_cnt_o <= cnt_inc;
                sat_o      <= sat_inc;
                cnt_q      <= '0;
                sat_q      <= 1'b0;
            end else if (count_en) begin
                cnt_q <= cnt_inc;
                sat_q <= sat_inc;
            end else begin
                cnt_q <= '0;
                sat_q <= 1'b0;
            end
        end
    end

    // Band comparison one bit wider than the count so target+deadband cannot wrap
    always_comb begin
        cnt_ext = {1'b0, edge_cnt_o};
        tgt_ext = {1'b0, target_cnt_i};
        db_ext  = {1'b0, deadband_i};
        fast    = cnt_ext > (tgt_ext + db_ext);
        slow    = (cnt_ext + db_ext) < tgt_ext;
        fast_run_nxt = '0;
        slow_run_nxt = '0;
        if (fast) fast_run_nxt = (fast_run_q >= RUN_MAX) ? RUN_MAX : fast_run_q + RUN_W'(1);
        if (slow) slow_run_nxt = (slow_run_q >= RUN_MAX) ? RUN_MAX : slow_run_q + RUN_W'(1);
        fast_set = cnt_valid_o && fast && (fast_run_nxt == RUN_MAX);
        slow_set = cnt_valid_o && slow && (slow_run_nxt == RUN_MAX);
    end

    // Run counters and sticky interrupts; a set beats a coincident clear
    always_ff @(posedge CLK_IP_i) begin
        if (RST_IP_i) begin
            fast_run_q           <= '0;
            slow_run_q           <= '0;
            Interrupt_speedup_o  <= 1'b0;
            Interrupt_slowdown_o <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                fast_run_q <= '0;
                slow_run_q <= '0;
            end else if (cnt_valid_o) begin
                fast_run_q <= fast_run_nxt;
                slow_run_q <= slow_run_nxt;
            end
            if (fast_set) begin
                Interrupt_speedup_o  <= 1'b1;
                Interrupt_slowdown_o <= 1'b0;
            end else if (slow_set) begin
                Interrupt_slowdown_o <= 1'b1;
                Interrupt_speedup_o  <= 1'b0;
            end else begin
                if (int_clr_i[1]) Interrupt_speedup_o  <= 1'b0;
                if (int_clr_i[0]) Interrupt_slowdown_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fll_rate_monitor.sv
// Directed bench for fll_rate_monitor: a default-width instance (a) and a
// 4-bit counter instance (b) for saturation and window clamp.
module tb_fll_rate_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mclk = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [15:0] win_a = 16'd64, tgt_a = 16'd16, db_a = 16'd1;
    logic [1:0]  clr_a = 2'b00, clr_b = 2'b00;
    logic [15:0] win_b = 16'd64;
    logic [3:0]  tgt_b = 4'd8, db_b = 4'd1;

    logic        spd_a, slw_a, vld_a, sat_a;
    logic [15:0] edge_a;
    logic        spd_b, slw_b, vld_b, sat_b;
    logic [3:0]  edge_b;

    int checks = 0;
    int failures = 0;
    int div_n = 0;
    int ph = 0;

    fll_rate_monitor u_dut_a (
        .CLK_IP_i(clk), .RST_IP_i(rst), .enable_i(en_a), .bitclk_master_i(mclk),
        .window_len_i(win_a), .target_cnt_i(tgt_a), .deadband_i(db_a), .int_clr_i(clr_a),
        .Interrupt_speedup_o(spd_a), .Interrupt_slowdown_o(slw_a),
        .edge_cnt_o(edge_a), .cnt_valid_o(vld_a), .sat_o(sat_a)
    );

    fll_rate_monitor #(.CNT_W(4)) u_dut_b (
        .CLK_IP_i(clk), .RST_IP_i(rst), .enable_i(en_b), .bitclk_master_i(mclk),
        .window_len_i(win_b), .target_cnt_i(tgt_b), .deadband_i(db_b), .int_clr_i(clr_b),
        .Interrupt_speedup_o(spd_b), .Interrupt_slowdown_o(slw_b),
        .edge_cnt_o(edge_b), .cnt_valid_o(vld_b), .sat_o(sat_b)
    );

    always #5 clk = ~clk;

    // Master bit clock = local / div_n (one rising edge per div_n cycles)
    always @(posedge clk) begin
        #1;
        if (div_n < 2) begin
            mclk = 1'b0;
        end else begin
            ph   = (ph + 1 >= div_n) ? 0 : ph + 1;
            mclk = (ph < div_n / 2);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input bit sel, input int budget, output int cycles);
        logic found;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if ((sel ? vld_b : vld_a) === 1'b1) found = 1'b1;
        end
        if (!found) check("valid_timeout", {31'b0, found}, 1);
    endtask

    task automatic no_valid(input int n, output logic seen);
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (vld_a !== 1'b0) seen = 1'b1;
        end
    endtask

    initial begin
        int   c;
        logic seen;
        logic inr;

        // Reset state
        tick(3);
        check("rst_edge_cnt", edge_a, 0);
        check("rst_valid", vld_a, 0);
        check("rst_sat", sat_a, 0);
        check("rst_speedup", spd_a, 0);
        check("rst_slowdown", slw_a, 0);
        check("rst_edge_cnt_b", edge_b, 0);
        rst = 1'b0;

        // Nominal lock: local/4 over 64 cycles -> exactly 16 edges
        div_n = 4;
        tick(4);
        en_a = 1'b1;
        wait_valid(0, 200, c);
        check("nom_latency", c, 68);
        check("nom_cnt_w1", edge_a, 16);
        tick(1);
        check("nom_pulse_width", vld_a, 0);
        wait_valid(0, 200, c);
        check("nom_period", c, 63);
        check("nom_cnt_w2", edge_a, 16);
        wait_valid(0, 200, c);
        check("nom_period_full", c, 64);
        tick(1);
        check("nom_no_speedup", spd_a, 0);
        check("nom_no_slowdown", slw_a, 0);
        en_a = 1'b0;
        tick(3);

        // Fast master: local/3 -> 21..22 edges, two windows to raise speedup
        div_n = 3;
        en_a = 1'b1;
        wait_valid(0, 200, c);
        inr = (edge_a >= 16'd21 && edge_a <= 16'd22);
        check("fast_cnt_range", {31'b0, inr}, 1);
        tick(1);
        check("fast_one_window", spd_a, 0);
        wait_valid(0, 200, c);
        check("fast_eval_cycle", spd_a, 0);
        tick(1);
        check("fast_two_windows", spd_a, 1);
        en_a = 1'b0;
        clr_a = 2'b11;
        tick(1);
        clr_a = 2'b00;
        check("clr_both_spd", spd_a, 0);
        tick(2);

        // Slow master: local/8 -> 8 edges, slowdown after two windows
        div_n = 8;
        en_a = 1'b1;
        wait_valid(0, 200, c);
        check("slow_cnt", edge_a, 8);
        wait_valid(0, 200, c);
        tick(1);
        check("slow_set", slw_a, 1);
        check("slow_no_speedup", spd_a, 0);

        // Direction flip to local/3: speedup sets and slowdown clears together
        div_n = 3;
        wait_valid(0, 200, c);
        wait_valid(0, 200, c);
        check("flip_pre_slw", slw_a, 1);
        check("flip_pre_spd", spd_a, 0);
        tick(1);
        check("flip_spd", spd_a, 1);
        check("flip_slw", slw_a, 0);

        // Clear races
        clr_a = 2'b10;
        tick(1);
        clr_a = 2'b00;
        check("clr_mid_window", spd_a, 0);
        wait_valid(0, 200, c);
        clr_a = 2'b10;
        tick(1);
        clr_a = 2'b00;
        check("set_wins_clear", spd_a, 1);

        // Disable mid-window keeps the interrupt and emits no pulse
        tick(28);
        en_a = 1'b0;
        no_valid(100, seen);
        check("dis_no_valid_fast", {31'b0, seen}, 0);
        check("dis_keep_speedup", spd_a, 1);
        clr_a = 2'b10;
        tick(1);
        clr_a = 2'b00;
        check("clr_later", spd_a, 0);

        // Nominal disable / re-enable / reset mid-window
        div_n = 4;
        tick(2);
        en_a = 1'b1;
        wait_valid(0, 200, c);
        check("reen_latency_1", c, 68);
        check("reen_cnt", edge_a, 16);
        check("reen_sat", sat_a, 0);
        tick(29);
        en_a = 1'b0;
        no_valid(100, seen);
        check("dis_no_valid_nom", {31'b0, seen}, 0);
        check("dis_keep_cnt", edge_a, 16);
        en_a = 1'b1;
        wait_valid(0, 200, c);
        check("reen_latency_2", c, 68);
        tick(29);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_edge_cnt", edge_a, 0);
        check("midrst_valid", vld_a, 0);
        check("midrst_sat", sat_a, 0);
        check("midrst_speedup", spd_a, 0);
        check("midrst_slowdown", slw_a, 0);
        no_valid(60, seen);
        check("midrst_no_valid", {31'b0, seen}, 0);
        en_a = 1'b0;

        // 4-bit counter: local/2 saturates at 15; window_len 0 clamps to 2
        div_n = 2;
        tick(2);
        en_b = 1'b1;
        wait_valid(1, 200, c);
        check("sat_cnt", edge_b, 15);
        check("sat_flag", sat_b, 1);
        win_b = 16'd0;
        wait_valid(1, 200, c);
        check("clamp_old_len", c, 64);
        wait_valid(1, 200, c);
        check("clamp_len_2", c, 2);
        check("clamp_cnt", edge_b, 1);
        check("clamp_sat", sat_b, 0);
        en_b = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
